fetch_unit: RTL

- Parametrised next-generation instruction fetch stage.
- Issues pipelined word fetches over a req/gnt/rvalid memory interface, with up to DEPTH requests in flight.
- Buffers returned instructions in a DEPTH-entry prefetch FIFO and hands them to ID with a valid/ready handshake.
- Sits between the instruction RAM and ID; EX redirects it via jump_flag_i/jump_addr_i, which flushes the FIFO and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int FETCH_XLEN  = 32;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   // One prefetch buffer entry: the instruction and the address it came from.
   typedef struct packed {
      logic [FETCH_XLEN-1:0] addr;
      logic [FETCH_XLEN-1:0] rdata;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: synchronous, flushable, with wrap-bit pointers.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  entry_t                   push_data_i,
   input  logic                     pop_i,
   output entry_t                   head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   entry_t      mem_q [DEPTH];
   entry_t      mem_d [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Flush wins over push and pop; push into a full FIFO is dropped.
   always_comb begin
      do_push  = push_i && !full_o && !flush_i;
      do_pop   = pop_i && !empty_o && !flush_i;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
      end
   end

   // Pointer and storage registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pipelined req/gnt/rvalid fetches into a prefetch
// FIFO, redirected by EX jumps.
//
// Handshakes: a request transfers on the cycle instr_req_o && instr_gnt_i;
// req and address stay stable until granted unless a jump withdraws them.
// ID takes the head on instr_valid_id_o && id_ready_i; valid never depends
// on ready.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            fetch_en_i,
   input  logic [XLEN-1:0] boot_addr_i,
   output logic            instr_req_o,
   output logic [XLEN-1:0] instr_addr_o,
   input  logic            instr_gnt_i,
   input  logic            instr_rvalid_i,
   input  logic [XLEN-1:0] instr_rdata_i,
   input  logic            jump_flag_i,
   input  logic [XLEN-1:0] jump_addr_i,
   output logic            instr_valid_id_o,
   output logic [XLEN-1:0] instr_rdata_id_o,
   output logic [XLEN-1:0] instr_addr_id_o,
   input  logic            id_ready_i
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
   localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] rdata;
   } entry_t;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
   logic [XLEN-1:0] rsp_addr_q, rsp_addr_d;
   logic [AW:0]     outstanding_q, outstanding_d;
   logic [AW:0]     discard_q, discard_d;

   logic [XLEN-1:0] boot_aligned;
   logic [XLEN-1:0] jump_aligned;
   logic [AW:0]     grant_w;
   logic [AW:0]     rvalid_w;
   logic [AW+1:0]   credit_used;
   logic            grant;
   logic            jump_act;

   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [AW:0]     fifo_count;
   entry_t          fifo_wdata;
   entry_t          fifo_head;
   logic            unused_low_bits;

   assign boot_aligned    = {boot_addr_i[XLEN-1:2], 2'b00};
   assign jump_aligned    = {jump_addr_i[XLEN-1:2], 2'b00};
   assign unused_low_bits = ^{boot_addr_i[1:0], jump_addr_i[1:0]};

   // Credit: in-flight plus buffered never exceeds DEPTH, so pushes always fit.
   assign credit_used  = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign instr_req_o  = (state_q == RUN) && !jump_flag_i && (credit_used < DEPTH_W);
   assign instr_addr_o = fetch_addr_q;
   assign grant        = instr_req_o && instr_gnt_i;
   assign grant_w      = {{AW{1'b0}}, grant};
   assign rvalid_w     = {{AW{1'b0}}, instr_rvalid_i};
   assign jump_act     = jump_flag_i && (state_q != BOOT);

   // FSM next state; RUN only leaves once no request is left hanging.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT: if (fetch_en_i) state_d = RUN;
         RUN:  if (!fetch_en_i && !(instr_req_o && !instr_gnt_i)) state_d = HALT;
         HALT: if (fetch_en_i) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   // Address, credit and discard bookkeeping; a jump overrides everything.
   always_comb begin
      fetch_addr_d  = fetch_addr_q;
      rsp_addr_d    = rsp_addr_q;
      outstanding_d = outstanding_q + grant_w - rvalid_w;
      discard_d     = discard_q;
      fifo_push     = 1'b0;
      if (state_q == BOOT) begin
         if (fetch_en_i) begin
            fetch_addr_d = boot_aligned;
            rsp_addr_d   = boot_aligned;
         end
      end else if (jump_act) begin
         discard_d    = outstanding_q - rvalid_w;
         fetch_addr_d = jump_aligned;
         rsp_addr_d   = jump_aligned;
      end else begin
         if (grant) begin
            fetch_addr_d = fetch_addr_q + STEP;
         end
         if (instr_rvalid_i) begin
            if (discard_q != '0) begin
               discard_d = discard_q - {{AW{1'b0}}, 1'b1};
            end else begin
               fifo_push  = 1'b1;
               rsp_addr_d = rsp_addr_q + STEP;
            end
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= BOOT;
         fetch_addr_q  <= '0;
         rsp_addr_q    <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         rsp_addr_q    <= rsp_addr_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   assign fifo_wdata = '{addr: rsp_addr_q, rdata: instr_rdata_i};
   assign fifo_pop   = !fifo_empty && id_ready_i;

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (jump_act),
      .push_i      (fifo_push),
      .push_data_i (fifo_wdata),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign instr_valid_id_o = !fifo_empty;
   assign instr_rdata_id_o = fifo_head.rdata;
   assign instr_addr_id_o  = fifo_head.addr;

   // The credit rule must keep responses from ever hitting a full FIFO.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(fifo_push && fifo_full));
      end
   end

endmodule
